// File: rtl/uart_frame_pkg.sv
// Shared types for the UART frame loader: RX and loader state encodings plus bit-timing helper.
// The PARITY state exists only when UART_PARITY_EN is defined.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_PARITY_EN
        PARITY,
`endif
        STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        L_IDLE,
        L_LOAD,
        L_DONE
    } load_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM, one-cycle rx_valid/rx_err strobes.
// Define UART_PARITY_EN to expect an even-parity bit between the data and stop bits.
module uart_rx_core
    import uart_frame_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int STOP_BITS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_err
);

    localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int HALF  = CPB / 2;
    localparam int CNT_W = $clog2(CPB + 1);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    logic [1:0]       sync_q;
    logic             rx_s;
    rx_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_n;
    logic             stop_idx, stop_n;
    logic [7:0]       shift, shift_n;
    logic             bad, bad_n;
    logic             valid_n, err_n;
    logic [7:0]       data_n;

    assign rx_s = sync_q[1];

    // Idle-high line: the synchroniser resets to 1 so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= 2'b11;
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shift    <= '0;
            bad      <= 1'b0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            rx_data  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            sync_q   <= {sync_q[0], rxd};
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_n;
            stop_idx <= stop_n;
            shift    <= shift_n;
            bad      <= bad_n;
            rx_valid <= valid_n;
            rx_err   <= err_n;
            rx_data  <= data_n;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        state_n = state;
        cnt_n   = cnt + 1'b1;
        bit_n   = bit_idx;
        stop_n  = stop_idx;
        shift_n = shift;
        bad_n   = bad;
        valid_n = 1'b0;
        err_n   = 1'b0;
        data_n  = rx_data;
        case (state)
            IDLE: begin
                cnt_n  = '0;
                bit_n  = '0;
                stop_n = 1'b0;
                bad_n  = 1'b0;
                if (!rx_s) state_n = START;
            end
            START: begin
                // A line that is high again at mid start bit was only a glitch.
                if (cnt == CNT_W'(HALF - 1)) begin
                    cnt_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CNT_W'(CPB - 1)) begin
                    cnt_n   = '0;
                    shift_n = {rx_s, shift[7:1]};
                    bit_n   = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (cnt == CNT_W'(CPB - 1)) begin
                    cnt_n   = '0;
                    state_n = STOP;
                    if (rx_s != ^shift) bad_n = 1'b1;
                end
            end
`endif
            STOP: begin
                if (cnt == CNT_W'(CPB - 1)) begin
                    cnt_n  = '0;
                    stop_n = stop_idx + 1'b1;
                    bad_n  = bad | ~rx_s;
                    if (stop_idx == STOP_LAST) begin
                        state_n = IDLE;
                        if (bad || !rx_s) begin
                            err_n = 1'b1;
                        end else begin
                            valid_n = 1'b1;
                            data_n  = shift;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_frame_loader.sv
// Loads a frame of pixels received over UART into memory, one pixel per byte, starting on arm.
// Define UART_PARITY_EN to enable even-parity checking in the receiver.
module uart_frame_loader
    import uart_frame_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD_RATE    = 115200,
    parameter int STOP_BITS    = 2,
    parameter int PIXEL_BITS   = 3,
    parameter int FRAME_PIXELS = 76800,
    parameter int ADDR_W       = 17,
    parameter int TIMEOUT_BITS = 20,
    parameter int WRAP         = 0
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET,
    input  logic                  UART_RXD,
    input  logic                  arm,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [PIXEL_BITS-1:0] mem_data,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_err,
    output logic [7:0]            last_byte,
    output logic [ADDR_W-1:0]     byte_count
);

    localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int TMO_W          = $clog2(TIMEOUT_CYCLES + 1);

    logic             rx_valid, rx_err;
    logic [7:0]       rx_data;
    load_state_t      state, state_n;
    logic [ADDR_W-1:0] count_n, addr_n;
    logic [PIXEL_BITS-1:0] data_n;
    logic             we_n, done_n, err_n;
    logic [TMO_W-1:0] tmo_cnt, tmo_n;

    uart_rx_core #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE),
        .STOP_BITS(STOP_BITS)
    ) u_rx (
        .clk     (CLOCK_50),
        .rst     (RESET),
        .rxd     (UART_RXD),
        .rx_valid(rx_valid),
        .rx_data (rx_data),
        .rx_err  (rx_err)
    );

    // The receiver only updates rx_data on a good byte, so it already is the LED value.
    assign last_byte = rx_data;
    assign busy      = (state == L_LOAD);

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state      <= L_IDLE;
            byte_count <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            tmo_cnt    <= '0;
        end else begin
            state      <= state_n;
            byte_count <= count_n;
            mem_we     <= we_n;
            mem_addr   <= addr_n;
            mem_data   <= data_n;
            frame_done <= done_n;
            frame_err  <= err_n;
            tmo_cnt    <= tmo_n;
        end
    end

    always_comb begin
        state_n = state;
        count_n = byte_count;
        addr_n  = mem_addr;
        data_n  = mem_data;
        we_n    = 1'b0;
        done_n  = 1'b0;
        err_n   = frame_err;
        tmo_n   = '0;
        if (arm) begin
            // arm wins over a byte completing in the same cycle; that byte is dropped.
            state_n = L_LOAD;
            count_n = '0;
            addr_n  = '0;
            err_n   = 1'b0;
        end else begin
            if (rx_err) err_n = 1'b1;
            if (state == L_LOAD) begin
                if (rx_valid) begin
                    we_n   = 1'b1;
                    addr_n = byte_count;
                    data_n = rx_data[PIXEL_BITS-1:0];
                    if (byte_count == ADDR_W'(FRAME_PIXELS - 1)) begin
                        // Frame complete: the count restarts so an address past the frame is never formed.
                        done_n  = 1'b1;
                        count_n = '0;
                        if (WRAP == 0) state_n = L_DONE;
                    end else begin
                        count_n = byte_count + 1'b1;
                    end
                end else if (byte_count != '0) begin
                    if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        count_n = '0;
                        err_n   = 1'b1;
                    end else begin
                        tmo_n = tmo_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Directed bench for uart_frame_loader: two instances (WRAP=0 and WRAP=1) share one serial line.
// A byte-level model predicts writes and status; a negedge process checks every write strobe.
module tb_uart_frame_loader;

    localparam int CPB      = 16;   // 1_843_200 Hz / 115200 baud
    localparam int TMO_BITS = 20;
    localparam int GAP_BITS = 2;    // idle bit-times after each frame

    logic clk = 1'b0;
    logic rst;
    logic rxd;
    logic arm;

    logic       we    [2];
    logic [2:0] addr  [2];
    logic [2:0] data  [2];
    logic       busy  [2];
    logic       done  [2];
    logic       err   [2];
    logic [7:0] lastb [2];
    logic [2:0] cnt   [2];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [2:0] addr;
        logic [2:0] data;
        logic       done;
    } wr_t;

    wr_t q0[$];
    wr_t q1[$];

    // Model state: index 0 is the WRAP=0 instance, index 1 the WRAP=1 instance.
    bit         m_load  [2];
    int         m_count [2];
    bit         m_err   [2];
    logic [7:0] m_last;

    int last_addr [2];
    int last_data [2];
    int done_seen [2];

    always #10 clk = ~clk;

    uart_frame_loader #(
        .CLK_FREQ(1_843_200), .BAUD_RATE(115200), .STOP_BITS(2), .PIXEL_BITS(3),
        .FRAME_PIXELS(8), .ADDR_W(3), .TIMEOUT_BITS(TMO_BITS), .WRAP(0)
    ) dut (
        .CLOCK_50(clk), .RESET(rst), .UART_RXD(rxd), .arm(arm),
        .mem_we(we[0]), .mem_addr(addr[0]), .mem_data(data[0]), .busy(busy[0]),
        .frame_done(done[0]), .frame_err(err[0]), .last_byte(lastb[0]), .byte_count(cnt[0])
    );

    uart_frame_loader #(
        .CLK_FREQ(1_843_200), .BAUD_RATE(115200), .STOP_BITS(2), .PIXEL_BITS(3),
        .FRAME_PIXELS(8), .ADDR_W(3), .TIMEOUT_BITS(TMO_BITS), .WRAP(1)
    ) dut_w (
        .CLOCK_50(clk), .RESET(rst), .UART_RXD(rxd), .arm(arm),
        .mem_we(we[1]), .mem_addr(addr[1]), .mem_data(data[1]), .busy(busy[1]),
        .frame_done(done[1]), .frame_err(err[1]), .last_byte(lastb[1]), .byte_count(cnt[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    task automatic push(input int k, input wr_t w);
        if (k == 0) q0.push_back(w);
        else        q1.push_back(w);
    endtask

    task automatic pop(input int k, output wr_t w);
        if (k == 0) w = q0.pop_front();
        else        w = q1.pop_front();
    endtask

    always @(negedge clk) begin
        wr_t w;
        for (int k = 0; k < 2; k++) begin
            if (we[k] === 1'b1) begin
                if (qsize(k) == 0) begin
                    check($sformatf("unexpected_we[%0d]", k), 32'(we[k]), 32'd0);
                end else begin
                    pop(k, w);
                    check($sformatf("wr_addr[%0d]", k), 32'(addr[k]), 32'(w.addr));
                    check($sformatf("wr_data[%0d]", k), 32'(data[k]), 32'(w.data));
                    check($sformatf("wr_done[%0d]", k), 32'(done[k]), 32'(w.done));
                    last_addr[k] = int'(addr[k]);
                    last_data[k] = int'(data[k]);
                    if (done[k] === 1'b1) done_seen[k]++;
                end
            end else if (done[k] === 1'b1) begin
                check($sformatf("done_without_we[%0d]", k), 32'(done[k]), 32'd0);
            end
        end
    end

    task automatic model_byte(input logic [7:0] b, input bit good);
        wr_t w;
        for (int k = 0; k < 2; k++) begin
            if (!good) begin
                m_err[k] = 1'b1;
            end else if (m_load[k]) begin
                w.addr = 3'(m_count[k]);
                w.data = b[2:0];
                w.done = (m_count[k] == 7);
                push(k, w);
                if (m_count[k] == 7) begin
                    m_count[k] = 0;
                    if (k == 0) m_load[k] = 1'b0;   // only the WRAP=0 instance stops
                end else begin
                    m_count[k]++;
                end
            end
        end
        if (good) m_last = b;
    endtask

    task automatic drive_bit(input logic v);
        rxd = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop, input bit bad_par);
        model_byte(b, !bad_stop && !bad_par);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_PARITY_EN
        drive_bit((^b) ^ bad_par);
`endif
        drive_bit(!bad_stop);
        drive_bit(1'b1);
        repeat (GAP_BITS) drive_bit(1'b1);
    endtask

    task automatic idle_bits(input int n);
        for (int k = 0; k < 2; k++) begin
            if (m_load[k] && m_count[k] != 0 && n + GAP_BITS > TMO_BITS) begin
                m_count[k] = 0;
                m_err[k]   = 1'b1;
            end
        end
        repeat (n) drive_bit(1'b1);
    endtask

    task automatic arm_pulse();
        @(posedge clk);
        #1 arm = 1'b1;
        @(posedge clk);
        #1 arm = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_load[k]  = 1'b1;
            m_count[k] = 0;
            m_err[k]   = 1'b0;
        end
    endtask

    task automatic check_state(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_busy[%0d]", tag, k), 32'(busy[k]), 32'(m_load[k]));
            check($sformatf("%s_count[%0d]", tag, k), 32'(cnt[k]), 32'(m_count[k]));
            check($sformatf("%s_err[%0d]", tag, k), 32'(err[k]), 32'(m_err[k]));
            check($sformatf("%s_last[%0d]", tag, k), 32'(lastb[k]), 32'(m_last));
            check($sformatf("%s_pending[%0d]", tag, k), 32'(qsize(k)), 32'd0);
        end
    endtask

    task automatic check_reset(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_we[%0d]", tag, k), 32'(we[k]), 32'd0);
            check($sformatf("%s_addr[%0d]", tag, k), 32'(addr[k]), 32'd0);
            check($sformatf("%s_data[%0d]", tag, k), 32'(data[k]), 32'd0);
            check($sformatf("%s_busy[%0d]", tag, k), 32'(busy[k]), 32'd0);
            check($sformatf("%s_done[%0d]", tag, k), 32'(done[k]), 32'd0);
            check($sformatf("%s_err[%0d]", tag, k), 32'(err[k]), 32'd0);
            check($sformatf("%s_last[%0d]", tag, k), 32'(lastb[k]), 32'd0);
            check($sformatf("%s_count[%0d]", tag, k), 32'(cnt[k]), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        rxd = 1'b1;
        arm = 1'b0;
        m_last = 8'h00;
        for (int k = 0; k < 2; k++) begin
            m_load[k] = 1'b0; m_count[k] = 0; m_err[k] = 1'b0;
            last_addr[k] = 0; last_data[k] = 0; done_seen[k] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Full frame of pixels 0..7.
        arm_pulse();
        for (int i = 0; i < 8; i++) send_byte(8'(i), 1'b0, 1'b0);
        check_state("frame");
        check("frame_last_addr", 32'(last_addr[0]), 32'd7);
        check("frame_last_data", 32'(last_data[0]), 32'd7);
        check("frame_done_once", 32'(done_seen[0]), 32'd1);
        check("frame_busy_fell", 32'(busy[0]), 32'd0);
        check("wrap_busy_held", 32'(busy[1]), 32'd1);

        // Byte after frame end: display only for WRAP=0, address 0 for WRAP=1.
        send_byte(8'hAA, 1'b0, 1'b0);
        check_state("post_frame");
        check("post_frame_last", 32'(lastb[0]), 32'h0000_00AA);
        check("post_frame_addr_hold", 32'(last_addr[0]), 32'd7);
        check("wrap_addr", 32'(last_addr[1]), 32'd0);
        check("wrap_data", 32'(last_data[1]), 32'b010);

        // Short low glitch (well under half a bit) must not produce a byte.
        arm_pulse();
        rxd = 1'b0;
        repeat (5) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (3) drive_bit(1'b1);
        check_state("glitch");
        check("glitch_last", 32'(lastb[0]), 32'h0000_00AA);

        // Framing error: first stop bit low.
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        send_byte(8'h55, 1'b1, 1'b0);
        check_state("bad_stop");
        check("bad_stop_count", 32'(cnt[0]), 32'd2);
        check("bad_stop_err", 32'(err[0]), 32'd1);
        check("bad_stop_last", 32'(lastb[0]), 32'h0000_0022);

        // Inter-byte timeout after three bytes.
        arm_pulse();
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h03, 1'b0, 1'b0);
        check_state("pre_timeout");
        idle_bits(25);
        check_state("timeout");
        check("timeout_count", 32'(cnt[0]), 32'd0);
        check("timeout_err", 32'(err[0]), 32'd1);
        send_byte(8'h04, 1'b0, 1'b0);
        check_state("after_timeout");
        check("after_timeout_addr", 32'(last_addr[0]), 32'd0);
        check("after_timeout_data", 32'(last_data[0]), 32'd4);

        // Reset in the middle of the data bits of 0xFF: byte lost, no write.
        arm_pulse();
        drive_bit(1'b0);
        repeat (3) drive_bit(1'b1);
        repeat (CPB / 2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("reset_mid_byte");
        @(posedge clk);
        #1 rst = 1'b0;
        m_last = 8'h00;
        for (int k = 0; k < 2; k++) begin
            m_load[k] = 1'b0; m_count[k] = 0; m_err[k] = 1'b0;
        end
        repeat (8) drive_bit(1'b1);
        check_state("after_reset");

`ifdef UART_PARITY_EN
        // Bad parity: discarded, error flagged.
        arm_pulse();
        send_byte(8'h01, 1'b0, 1'b1);
        check_state("bad_parity");
        check("bad_parity_err", 32'(err[0]), 32'd1);
        check("bad_parity_count", 32'(cnt[0]), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
